// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-side branch resolution, redirect/flush and BTB update.
// Define BRU_STATS_EN to add saturating branch and mispredict counters.
module branch_resolve_unit #(
    parameter int PC_W   = 5,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              F_valid,
    input  logic [PC_W-1:0]   F_pc,
    input  logic              F_BP_taken,
    input  logic [PC_W-1:0]   F_BP_target_pc,
    input  logic              F_stall,
    input  logic              MEM_stall,
    input  logic              EX_brn,
    input  logic              EX_cond,
    input  logic [PC_W-1:0]   EX_alu_out,
    output logic [PC_W-1:0]   EX_pc,
    output logic              EX_valid,
    output logic              BU_update,
    output logic              BU_true_taken,
    output logic [PC_W-1:0]   BU_target,
    output logic              BU_mispredict,
    output logic [PC_W-1:0]   BU_redirect_pc,
`ifdef BRU_STATS_EN
    output logic [STAT_W-1:0] BU_branch_cnt,
    output logic [STAT_W-1:0] BU_mispred_cnt,
`endif
    output logic              BU_flush
);
    typedef enum logic {RUN, RECOVER} state_t;
    state_t state, state_nx;
    logic d_valid, d_pt, ex_pt, live;
    logic [PC_W-1:0] d_pc, d_tgt, ex_tgt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RUN;
        else state <= state_nx;

    // A predicted-taken non-branch in EX is a stale BTB alias and redirects to fall-through.
    always_comb begin
        live = EX_valid && !MEM_stall && state == RUN;
        BU_update = live && EX_brn;
        BU_true_taken = EX_cond;
        BU_target = EX_alu_out;
        BU_mispredict = EX_brn ? BU_update && (ex_pt != EX_cond || (EX_cond && ex_tgt != EX_alu_out))
                               : live && ex_pt;
        BU_redirect_pc = !BU_mispredict ? '0 : (EX_brn && EX_cond) ? EX_alu_out : EX_pc + PC_W'(1);
        state_nx = BU_mispredict ? RECOVER : RUN;
        BU_flush = state == RECOVER;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid  <= 1'b0;
            d_pc     <= '0;
            d_pt     <= 1'b0;
            d_tgt    <= '0;
            EX_valid <= 1'b0;
            EX_pc    <= '0;
            ex_pt    <= 1'b0;
            ex_tgt   <= '0;
        end else begin
            if (!F_stall && !MEM_stall) begin
                d_pc  <= F_pc;
                d_pt  <= F_BP_taken;
                d_tgt <= F_BP_target_pc;
            end
            if (!MEM_stall) begin
                EX_pc  <= d_pc;
                ex_pt  <= d_pt;
                ex_tgt <= d_tgt;
            end
            d_valid  <= BU_mispredict ? 1'b0 : (F_stall || MEM_stall) ? d_valid : F_valid;
            EX_valid <= BU_mispredict ? 1'b0 : MEM_stall ? EX_valid : d_valid && !F_stall;
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BU_branch_cnt  <= '0;
            BU_mispred_cnt <= '0;
        end else begin
            if (BU_update && !(&BU_branch_cnt)) BU_branch_cnt <= BU_branch_cnt + STAT_W'(1);
            if (BU_mispredict && !(&BU_mispred_cnt)) BU_mispred_cnt <= BU_mispred_cnt + STAT_W'(1);
        end
    end
`endif
endmodule
